// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared widths and pointer/count types for the 16-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;
    localparam int FIFO_AW    = 4;
    localparam int FIFO_PW    = 5;
    localparam int FIFO_DEPTH = 16;

    typedef logic [FIFO_PW-1:0] ptr_t;
    typedef logic [FIFO_PW-1:0] cnt_t;
endpackage

`default_nettype wire

// File: rtl/addsub5.sv
// ============================================================================
// Module      : addsub5
// Description : 5-bit adder/subtractor, z = a + b or a - b, with carry-out
//               and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub5 (
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       sub,
    output logic [4:0] z,
    output logic       co,
    output logic       oflow
);
    logic [4:0] w_b_eff;

    // Subtraction as a + ~b + 1
    assign w_b_eff     = sub ? ~b : b;
    assign {co, z}     = {1'b0, a} + {1'b0, w_b_eff} + {5'd0, sub};
    assign oflow       = (a[4] == w_b_eff[4]) && (z[4] != a[4]);
endmodule

`default_nettype wire

// File: rtl/fifo_ptr_cnt.sv
// ============================================================================
// Module      : fifo_ptr_cnt
// Description : 5-bit wrapping FIFO pointer (4 address bits + lap bit) with
//               increment enable and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ptr_cnt
    import fifo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output ptr_t ptr,
    output ptr_t ptr_nxt
);
    ptr_t r_ptr;

    // Natural 5-bit rollover gives the 31 -> 0 wrap and the lap-bit flip
    assign ptr_nxt = r_ptr + ptr_t'(inc);
    assign ptr     = r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= ptr_nxt;
        end
    end
endmodule

`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
// ============================================================================
// Module      : fifo_ptr_ctrl
// Description : Read/write pointer and status controller for a 16-entry FIFO.
//               Optional sticky overflow/underflow flags: FIFO_ERR_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_req,
    input  logic               rd_req,
    output logic               wr_en,
    output logic               rd_en,
    output logic [FIFO_AW-1:0] wr_addr,
    output logic [FIFO_AW-1:0] rd_addr,
    output logic [FIFO_PW-1:0] count,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               ovf_err,
    output logic               udf_err
);
    localparam cnt_t C_AF_LEVEL = cnt_t'(AF_LEVEL);
    localparam cnt_t C_AE_LEVEL = cnt_t'(AE_LEVEL);
    localparam cnt_t C_DEPTH    = cnt_t'(FIFO_DEPTH);

    ptr_t w_wr_ptr;
    ptr_t w_rd_ptr;
    ptr_t w_wr_ptr_nxt;
    ptr_t w_rd_ptr_nxt;
    cnt_t w_count_nxt;
    logic w_co_unused;
    logic w_oflow_unused;

    cnt_t r_count;
    logic r_full;
    logic r_empty;
    logic r_almost_full;
    logic r_almost_empty;

    assign wr_en = wr_req & ~r_full;
    assign rd_en = rd_req & ~r_empty;

    fifo_ptr_cnt u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .inc     (wr_en),
        .ptr     (w_wr_ptr),
        .ptr_nxt (w_wr_ptr_nxt)
    );

    fifo_ptr_cnt u_rd_ptr (
        .clk     (clk),
        .rst     (rst),
        .inc     (rd_en),
        .ptr     (w_rd_ptr),
        .ptr_nxt (w_rd_ptr_nxt)
    );

    // Occupancy never exceeds 16, so the 5-bit difference is exact
    addsub5 u_addsub5 (
        .a     (w_wr_ptr_nxt),
        .b     (w_rd_ptr_nxt),
        .sub   (1'b1),
        .z     (w_count_nxt),
        .co    (w_co_unused),
        .oflow (w_oflow_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == C_DEPTH);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= C_AF_LEVEL);
            r_almost_empty <= (w_count_nxt <= C_AE_LEVEL);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_ovf_err;
    logic r_udf_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            r_ovf_err <= r_ovf_err | (wr_req & r_full);
            r_udf_err <= r_udf_err | (rd_req & r_empty);
        end
    end

    assign ovf_err = r_ovf_err;
    assign udf_err = r_udf_err;
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

    assign wr_addr      = w_wr_ptr[FIFO_AW-1:0];
    assign rd_addr      = w_rd_ptr[FIFO_AW-1:0];
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
endmodule

`default_nettype wire

// File: tb/tb_fifo_ptr_ctrl.sv
// ============================================================================
// Module      : tb_fifo_ptr_ctrl
// Description : Self-checking bench for fifo_ptr_ctrl (vector table plus
//               queued expected state; honours FIFO_ERR_FLAGS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_ptr_ctrl;
    localparam int AF = 12;
    localparam int AE = 4;

    logic       clk;
    logic       rst;
    logic       wr_req;
    logic       rd_req;
    logic       wr_en;
    logic       rd_en;
    logic [3:0] wr_addr;
    logic [3:0] rd_addr;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       ovf_err;
    logic       udf_err;

    fifo_ptr_ctrl #(.AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit wr;
        bit rd;
        bit exp_wr_en;
        bit exp_rd_en;
        int exp_count;
    } vec_t;

    typedef struct {
        int count;
        bit full;
        bit empty;
        bit af;
        bit ae;
        int wa;
        int ra;
        bit ovf;
        bit udf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    int n_cmp = 0;
    int n_bad = 0;

    // bench model state
    int m_count = 0;
    int m_wr    = 0;
    int m_rd    = 0;
    bit m_ovf   = 0;
    bit m_udf   = 0;

    bit err_en;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t make_exp();
        exp_t e;
        e.count = m_count;
        e.full  = (m_count == 16);
        e.empty = (m_count == 0);
        e.af    = (m_count >= AF);
        e.ae    = (m_count <= AE);
        e.wa    = m_wr % 16;
        e.ra    = m_rd % 16;
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        return e;
    endfunction

    task automatic chk_state(input string tag, input exp_t e);
        chk({tag, ".count"}, int'(count), e.count);
        chk({tag, ".full"}, int'(full), int'(e.full));
        chk({tag, ".empty"}, int'(empty), int'(e.empty));
        chk({tag, ".almost_full"}, int'(almost_full), int'(e.af));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(e.ae));
        chk({tag, ".wr_addr"}, int'(wr_addr), e.wa);
        chk({tag, ".rd_addr"}, int'(rd_addr), e.ra);
        chk({tag, ".ovf_err"}, int'(ovf_err), int'(e.ovf));
        chk({tag, ".udf_err"}, int'(udf_err), int'(e.udf));
    endtask

    // One clock of stimulus: check enables before the edge, state after it
    task automatic step(input string tag, input bit wr, input bit rd,
                        input bit xw, input bit xr, input int xc);
        exp_t e;
        @(negedge clk);
        wr_req = wr;
        rd_req = rd;
        #1;
        chk({tag, ".wr_en"}, int'(wr_en), int'(xw));
        chk({tag, ".rd_en"}, int'(rd_en), int'(xr));
        if (err_en) begin
            if (wr && m_count == 16) m_ovf = 1'b1;
            if (rd && m_count == 0)  m_udf = 1'b1;
        end
        m_wr    = (m_wr + int'(xw)) % 32;
        m_rd    = (m_rd + int'(xr)) % 32;
        m_count = xc;
        sb.push_back(make_exp());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".ptrdiff"}, (m_wr - m_rd + 32) % 32, e.count);
        chk_state(tag, e);
    endtask

    initial begin
`ifdef FIFO_ERR_FLAGS_EN
        err_en = 1'b1;
`else
        err_en = 1'b0;
`endif
        wr_req = 1'b0;
        rd_req = 1'b0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_state("reset", make_exp());

        // Table: 16 writes, rejected 17th, full rd+wr, drain, empty rd+wr
        for (int i = 1; i <= 16; i++) vecs.push_back('{1, 0, 1, 0, i});
        vecs.push_back('{1, 0, 0, 0, 16});
        vecs.push_back('{1, 1, 0, 1, 15});
        vecs.push_back('{0, 1, 0, 1, 14});
        vecs.push_back('{1, 1, 1, 1, 14});
        for (int i = 13; i >= 0; i--) vecs.push_back('{0, 1, 0, 1, i});
        vecs.push_back('{1, 1, 1, 0, 1});
        vecs.push_back('{0, 1, 0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 0});
        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd,
                 vecs[i].exp_wr_en, vecs[i].exp_rd_en, vecs[i].exp_count);

        // Explicit almost_full threshold check on a second fill
        for (int i = 1; i <= 12; i++) begin
            step($sformatf("af%0d", i), 1, 0, 1, 0, i);
            chk($sformatf("af_edge%0d", i), int'(almost_full), int'(i >= 12));
        end
        for (int i = 11; i >= 3; i--) step($sformatf("dn%0d", i), 0, 1, 0, 1, i);

        // Steady count of 3 across the pointer wrap and lap-bit flip
        for (int i = 0; i < 40; i++) step($sformatf("wrap%0d", i), 1, 1, 1, 1, 3);
        for (int i = 0; i < 40; i++) begin
            step($sformatf("alt_w%0d", i), 1, 0, 1, 0, 4);
            step($sformatf("alt_r%0d", i), 0, 1, 0, 1, 3);
        end

        // Fill to 9 then assert reset asynchronously mid-cycle with a write pending
        for (int i = 4; i <= 9; i++) step($sformatf("pre%0d", i), 1, 0, 1, 0, i);
        chk("pre_rst.count", int'(count), 9);
        @(negedge clk);
        wr_req = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        m_count = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0;
        chk_state("async_rst", make_exp());
        wr_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_state("post_rst", make_exp());
        step("after_rst", 1, 0, 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
